// File: rtl/uart_rx_if.sv
// RX-side bus between the UART receive front end and the peripheral registers.
interface uart_rx_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          rx;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;
    logic          irq;

    modport master (
        output rx, rd_en, clr_err,
        input  rx_data, rx_valid, rx_count, frame_err, overrun, irq
    );

    modport slave (
        input  rx, rd_en, clr_err,
        output rx_data, rx_valid, rx_count, frame_err, overrun, irq
    );
endinterface

// File: rtl/uart_rx_unit.sv
// UART 8N1 receiver: 16x oversampling, byte FIFO, sticky error flags, level irq.
module uart_rx_unit #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OSR        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int unsigned DIV = CLK_HZ / (BAUD * OSR);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_e;

    logic          sync1_q, sync1_d, rx_s_q, rx_s_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_c;
    state_e        state_q, state_d;
    logic [3:0]    sc_q, sc_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_c, ferr_set_c;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_c, full_c, wr_c;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d, overrun_q, overrun_d;

    // Synchroniser and free-running baud tick, never re-phased by the line.
    always_comb begin
        sync1_d    = bus.rx;
        rx_s_d     = sync1_q;
        tick_c     = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
    end

    // Frame FSM next state: all progress gated by the oversampling tick.
    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        bi_d       = bi_q;
        shift_d    = shift_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        if (tick_c) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        sc_d    = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (sc_q == 4'(OSR / 2 - 1)) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            sc_d    = '0;
                            bi_d    = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (sc_q == 4'(OSR - 1)) begin
                        shift_d[bi_q] = rx_s_q;
                        sc_d          = '0;
                        bi_d          = bi_q + 3'd1;
                        if (bi_q == 3'd7) state_d = S_STOP;
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                S_STOP: begin
                    if (sc_q == 4'(OSR - 1)) begin
                        sc_d = '0;
                        if (rx_s_q) begin
                            push_c  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_set_c = 1'b1;
                            state_d    = S_WAIT_HIGH;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO, head register and sticky flags; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_c    = bus.rd_en && (count_q != '0);
        full_c   = (count_q == CW'(FIFO_DEPTH));
        wr_c     = push_c && (!full_c || pop_c);
        if (wr_c) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rx_valid_d = (count_d != '0);
        rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d] : 8'h00;

        if (ferr_set_c)       frame_err_d = 1'b1;
        else if (bus.clr_err) frame_err_d = 1'b0;
        else                  frame_err_d = frame_err_q;

        if (push_c && !wr_c)  overrun_d = 1'b1;
        else if (bus.clr_err) overrun_d = 1'b0;
        else                  overrun_d = overrun_q;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            state_q     <= S_IDLE;
            sc_q        <= '0;
            bi_q        <= '0;
            shift_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            sc_q        <= sc_d;
            bi_q        <= bi_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_count  = count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.irq       = rx_valid_q;
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit; clock scaled so one tick is 4 clk and one bit 64 clk.
module tb_uart_rx_unit;
    localparam int unsigned OSR        = 16;
    localparam int unsigned BAUD       = 9600;
    localparam int unsigned DIV        = 4;
    localparam int unsigned CLK_HZ     = BAUD * OSR * DIV;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BIT        = DIV * OSR;
    // Edges from an aligned start-bit edge to the stop-bit sampling edge.
    localparam int unsigned PUSH_EDGE  = DIV * (1 + OSR / 2 + 9 * OSR);

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_rx_unit #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #10 clk = ~clk;

    // Clock edges since reset release; ticks fall on edges that are multiples of DIV.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_count;
        logic       exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bus.rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        bus.rx = stop;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic pop();
        @(posedge clk);
        #1 bus.rd_en = 1'b1;
        @(posedge clk);
        #1 bus.rd_en = 1'b0;
    endtask

    task automatic clr();
        @(posedge clk);
        #1 bus.clr_err = 1'b1;
        @(posedge clk);
        #1 bus.clr_err = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, 32'(bus.rx_data), 32'(exp));
        pop();
    endtask

    task automatic check_empty(input string name);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.rx_valid), 32'd0);
        check({name, "_data"},  32'(bus.rx_data),  32'd0);
        check({name, "_count"}, 32'(bus.rx_count), 32'd0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{tx: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_count: 1, exp_ferr: 1'b0};
        vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_count: 1, exp_ferr: 1'b0};
        vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_count: 1, exp_ferr: 1'b0};
        vecs[3] = '{tx: 8'hC3, stop: 1'b0, exp_data: 8'h00, exp_count: 0, exp_ferr: 1'b1};
        vecs[4] = '{tx: 8'h6E, stop: 1'b1, exp_data: 8'h6E, exp_count: 1, exp_ferr: 1'b0};

        reset       = 1'b1;
        bus.rx      = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",  32'(bus.rx_data),   32'd0);
        check("rst_valid", 32'(bus.rx_valid),  32'd0);
        check("rst_count", 32'(bus.rx_count),  32'd0);
        check("rst_ferr",  32'(bus.frame_err), 32'd0);
        check("rst_ovr",   32'(bus.overrun),   32'd0);
        check("rst_irq",   32'(bus.irq),       32'd0);
        reset = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;

        // Single-frame vectors: receive, inspect head/flags, pop, clear.
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].tx, vecs[v].stop);
            bus.rx = 1'b1;
            repeat (BIT) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_data", v),  32'(bus.rx_data),   32'(vecs[v].exp_data));
            check($sformatf("v%0d_count", v), 32'(bus.rx_count),  32'(vecs[v].exp_count));
            check($sformatf("v%0d_valid", v), 32'(bus.rx_valid),  32'(vecs[v].exp_count != 0));
            check($sformatf("v%0d_irq", v),   32'(bus.irq),       32'(vecs[v].exp_count != 0));
            check($sformatf("v%0d_ferr", v),  32'(bus.frame_err), 32'(vecs[v].exp_ferr));
            pop();
            clr();
            check_empty($sformatf("v%0d_pop", v));
            check($sformatf("v%0d_ferr_clr", v), 32'(bus.frame_err), 32'd0);
        end

        // Pop on an empty FIFO does nothing.
        pop();
        check_empty("empty_pop");

        // Glitch shorter than half a bit is rejected, then a real byte follows.
        @(posedge clk);
        #1 bus.rx = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        check_empty("glitch");
        @(posedge clk);
        #1;
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        check("glitch_after_cnt", 32'(bus.rx_count), 32'd1);
        pop_expect("glitch_after_data", 8'h3C);
        check_empty("glitch_after_pop");

        // Framing error followed by a long break: one error, no bytes.
        @(posedge clk);
        #1;
        send_frame(8'h55, 1'b0);
        repeat (3 * BIT) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (BIT) @(posedge clk);
        @(negedge clk);
        check("ferr_set",   32'(bus.frame_err), 32'd1);
        check("ferr_count", 32'(bus.rx_count),  32'd0);
        @(posedge clk);
        #1;
        send_frame(8'h12, 1'b1);
        @(negedge clk);
        check("ferr_next_cnt",  32'(bus.rx_count),  32'd1);
        check("ferr_sticky",    32'(bus.frame_err), 32'd1);
        clr();
        @(negedge clk);
        check("ferr_cleared",   32'(bus.frame_err), 32'd0);
        pop_expect("ferr_next_data", 8'h12);
        check_empty("ferr_drain");

        // Overrun: fifth byte is dropped, first four retained in order.
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 4) begin
                @(negedge clk);
                check("full_no_ovr", 32'(bus.overrun), 32'd0);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("ovr_count", 32'(bus.rx_count), 32'd4);
        check("ovr_set",   32'(bus.overrun),  32'd1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovr_pop%0d", i), 8'(i));
        check_empty("ovr_drain");
        clr();
        @(negedge clk);
        check("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Full FIFO with push and pop on the same edge: no overrun, count held.
        @(posedge clk);
        #1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        do begin
            @(posedge clk);
            #1;
        end while (cyc % DIV != 0);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1 bus.rd_en = 1'b1;
                @(posedge clk);
                #1 bus.rd_en = 1'b0;
            end
        join
        @(negedge clk);
        check("bnd_count", 32'(bus.rx_count), 32'd4);
        check("bnd_ovr",   32'(bus.overrun),  32'd0);
        pop_expect("bnd_pop0", 8'h22);
        pop_expect("bnd_pop1", 8'h33);
        pop_expect("bnd_pop2", 8'h44);
        pop_expect("bnd_pop3", 8'h99);
        check_empty("bnd_drain");

        // Reset in the middle of a frame clears everything immediately.
        @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b1);
        @(negedge clk);
        check("mid_pre_cnt", 32'(bus.rx_count), 32'd1);
        @(posedge clk);
        #1 bus.rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 bus.rx = 1'b0;
            repeat (BIT) @(posedge clk);
        end
        #1 reset = 1'b1;
        #1;
        check("mid_rst_data",  32'(bus.rx_data),   32'd0);
        check("mid_rst_valid", 32'(bus.rx_valid),  32'd0);
        check("mid_rst_count", 32'(bus.rx_count),  32'd0);
        check("mid_rst_irq",   32'(bus.irq),       32'd0);
        check("mid_rst_ferr",  32'(bus.frame_err), 32'd0);
        check("mid_rst_ovr",   32'(bus.overrun),   32'd0);
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1);
        @(negedge clk);
        check("mid_after_data",  32'(bus.rx_data),  32'h81);
        check("mid_after_count", 32'(bus.rx_count), 32'd1);
        check("mid_after_ferr",  32'(bus.frame_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
